// File: rtl/forward_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: producer kinds, stall FSM states,
// scoreboard entry layout and a helper for the forward-select width.
package diaosi_types_pkg;

  // Widest register select an entry can hold; narrower selects are zero-extended.
  localparam int FWD_WSEL_W = 8;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LUI  = 2'd1,
    KIND_LOAD = 2'd2
  } fwd_kind_t;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } fwd_state_t;

  typedef struct packed {
    logic                  valid;
    logic [FWD_WSEL_W-1:0] wsel;
    fwd_kind_t             kind;
  } fwd_entry_t;

  // Bits needed to encode "register file" (0) plus stages 1..nstages.
  function automatic int fwd_sel_width(input int nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// Decode/hazard-controller side bus of the forwarding scoreboard.
// Optional statistics counters appear only when FWD_STATS_EN is defined.
interface forward_scoreboard_if #(
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int REGW    = 5
);
  localparam int SELW = $clog2(NSTAGES + 1);

  logic                   advance;
  logic                   flush;
  logic                   iss_valid;
  logic                   iss_wen;
  logic [REGW-1:0]        iss_wsel;
  logic [1:0]             iss_kind;
  logic [NSRC*REGW-1:0]   rsel;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic [NSRC*2-1:0]      fwd_kind;
  logic                   stall;
`ifdef FWD_STATS_EN
  logic [31:0]            stall_cycles;
  logic [31:0]            fwd_hits;
`endif

  modport master (
    output advance, flush, iss_valid, iss_wen, iss_wsel, iss_kind, rsel,
`ifdef FWD_STATS_EN
    input  stall_cycles, fwd_hits,
`endif
    input  fwd_sel, fwd_kind, stall
  );

  modport slave (
    input  advance, flush, iss_valid, iss_wen, iss_wsel, iss_kind, rsel,
`ifdef FWD_STATS_EN
    output stall_cycles, fwd_hits,
`endif
    output fwd_sel, fwd_kind, stall
  );

endinterface

// File: rtl/forward_scoreboard_match.sv
// One decode operand compared against every scoreboard stage; the youngest
// valid matching stage wins. No match selects the register file (0).
module fwd_stage_match
  import diaosi_types_pkg::*;
#(
  parameter  int NSTAGES = 3,
  parameter  int REGW    = 5,
  localparam int SELW    = fwd_sel_width(NSTAGES)
) (
  input  logic [REGW-1:0]          i_rsel,
  input  fwd_entry_t [NSTAGES-1:0] i_stages,
  output logic [SELW-1:0]          o_sel,
  output fwd_kind_t                o_kind,
  output logic                     o_match
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_sel   = '0;
    o_kind  = KIND_ALU;
    o_match = 1'b0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (i_stages[k].valid && (i_stages[k].wsel == FWD_WSEL_W'(i_rsel))) begin
        o_sel   = SELW'(k + 1);
        o_kind  = i_stages[k].kind;
        o_match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writes over NSTAGES stages,
// produces per-operand forward selects and runs the load-use stall FSM.
// Optional feature macro: FWD_STATS_EN adds stall_cycles / fwd_hits counters.
module forward_scoreboard
  import diaosi_types_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int REGW    = 5
) (
  input logic                  CLK,
  input logic                  nRST,
  forward_scoreboard_if.slave  bus
);

  localparam int SELW = fwd_sel_width(NSTAGES);

  // Index 0 holds stage 1 (youngest), index NSTAGES-1 the oldest stage.
  fwd_entry_t [NSTAGES-1:0] r_stages;
  fwd_state_t               r_state;

  fwd_entry_t               w_issEntry;
  logic [SELW-1:0]          w_opSel   [NSRC];
  fwd_kind_t                w_opKind  [NSRC];
  logic                     w_opMatch [NSRC];
  logic [NSRC*SELW-1:0]     w_fwdSel;
  logic [NSRC*2-1:0]        w_fwdKind;
  logic                     w_hazard;
  logic                     w_stall;

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    fwd_stage_match #(
      .NSTAGES (NSTAGES),
      .REGW    (REGW)
    ) u_match (
      .i_rsel   (bus.rsel[i*REGW +: REGW]),
      .i_stages (r_stages),
      .o_sel    (w_opSel[i]),
      .o_kind   (w_opKind[i]),
      .o_match  (w_opMatch[i])
    );
  end

  // Pack operand results and flag a load sitting in stage 1 that an operand needs.
  always_comb begin
    w_hazard  = 1'b0;
    w_fwdSel  = '0;
    w_fwdKind = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_fwdSel[i*SELW +: SELW] = w_opSel[i];
      w_fwdKind[i*2 +: 2]      = w_opKind[i];
      if (w_opMatch[i] && (w_opSel[i] == SELW'(1)) && (w_opKind[i] == KIND_LOAD)) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign w_stall = (r_state == LU_STALL) || w_hazard;

  // Build the entry decode would push; register 0 and stalled slots become bubbles.
  always_comb begin
    w_issEntry = '0;
    if (bus.iss_valid && bus.iss_wen && (bus.iss_wsel != '0) && !w_stall) begin
      w_issEntry.valid = 1'b1;
      w_issEntry.wsel  = FWD_WSEL_W'(bus.iss_wsel);
      w_issEntry.kind  = fwd_kind_t'(bus.iss_kind);
    end
  end

  // Shift the scoreboard on advance; a flush drops the stage-1 entry instead of shifting it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stages <= '0;
    end else if (bus.advance) begin
      for (int k = NSTAGES - 1; k >= 1; k--) begin
        r_stages[k] <= r_stages[k-1];
      end
      r_stages[0] <= w_issEntry;
      if (bus.flush) begin
        r_stages[1] <= '0;
        r_stages[0] <= '0;
      end
    end else if (bus.flush) begin
      r_stages[0].valid <= 1'b0;
    end
  end

  // Latch a load-use stall that cannot resolve this cycle; advance or flush releases it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard && !bus.advance && !bus.flush) begin
            r_state <= LU_STALL;
          end
        end
        LU_STALL: begin
          if (bus.advance || bus.flush) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.fwd_sel  = w_fwdSel;
  assign bus.fwd_kind = w_fwdKind;
  assign bus.stall    = w_stall;

`ifdef FWD_STATS_EN
  logic        w_anyFwd;
  logic [31:0] r_stallCycles;
  logic [31:0] r_fwdHits;

  // Any operand taking a forwarded value this cycle.
  always_comb begin
    w_anyFwd = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_opMatch[i]) begin
        w_anyFwd = 1'b1;
      end
    end
  end

  // Free-running wrap-around counters of stall cycles and forwarding advances.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stallCycles <= '0;
      r_fwdHits     <= '0;
    end else begin
      if (w_stall) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
      if (bus.advance && w_anyFwd) begin
        r_fwdHits <= r_fwdHits + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = r_stallCycles;
  assign bus.fwd_hits     = r_fwdHits;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Testbench for forward_scoreboard: directed scenarios plus random traffic,
// all compared against a list-based model of the in-flight writes.
// Stats counters are checked when FWD_STATS_EN is defined.
module tb_forward_scoreboard;
  import diaosi_types_pkg::*;

  localparam int NST  = 3;
  localparam int NSRC = 2;
  localparam int REGW = 5;
  localparam int SELW = $clog2(NST + 1);

  logic CLK;
  logic nRST;

  forward_scoreboard_if #(.NSTAGES(NST), .NSRC(NSRC), .REGW(REGW)) bus_if ();

  forward_scoreboard #(.NSTAGES(NST), .NSRC(NSRC), .REGW(REGW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Model: list of in-flight writes, position 1 = youngest.
  int mValid [1:NST];
  int mReg   [1:NST];
  int mKind  [1:NST];
  bit mLatched;
`ifdef FWD_STATS_EN
  int mStallCycles;
  int mFwdHits;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int dutSel(input int i);
    return int'(bus_if.fwd_sel[i*SELW +: SELW]);
  endfunction

  function automatic int dutKind(input int i);
    return int'(bus_if.fwd_kind[i*2 +: 2]);
  endfunction

  task automatic modelReset();
    for (int k = 1; k <= NST; k++) begin
      mValid[k] = 0;
      mReg[k]   = 0;
      mKind[k]  = 0;
    end
    mLatched = 1'b0;
`ifdef FWD_STATS_EN
    mStallCycles = 0;
    mFwdHits     = 0;
`endif
  endtask

  // Youngest in-flight writer of rs, or register file.
  task automatic modelLookup(input int rs, output int sel, output int kind);
    bit found;
    found = 1'b0;
    sel   = 0;
    kind  = 0;
    for (int k = 1; k <= NST; k++) begin
      if (!found && mValid[k] != 0 && mReg[k] == rs) begin
        sel   = k;
        kind  = mKind[k];
        found = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then clock it.
  task automatic applyStimulus(input bit adv, input bit fl, input bit v, input bit wen,
                               input int wsel, input int kind, input int rs0, input int rs1);
    int rs [NSRC];
    int s;
    int kd;
    bit hazard;
    bit anySel;
    bit expStall;
    bus_if.advance   = adv;
    bus_if.flush     = fl;
    bus_if.iss_valid = v;
    bus_if.iss_wen   = wen;
    bus_if.iss_wsel  = REGW'(wsel);
    bus_if.iss_kind  = 2'(kind);
    bus_if.rsel      = {REGW'(rs1), REGW'(rs0)};
    rs[0] = rs0;
    rs[1] = rs1;
    @(negedge CLK);
    hazard = 1'b0;
    anySel = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      modelLookup(rs[i], s, kd);
      checkOutput($sformatf("sel%0d", i), dutSel(i), s);
      checkOutput($sformatf("kind%0d", i), dutKind(i), kd);
      if (s == 1 && kd == 2) hazard = 1'b1;
      if (s != 0) anySel = 1'b1;
    end
    expStall = mLatched || hazard;
    checkOutput("stall", int'(bus_if.stall), int'(expStall));
    @(posedge CLK);
`ifdef FWD_STATS_EN
    if (expStall) mStallCycles++;
    if (adv && anySel) mFwdHits++;
`endif
    if (adv) begin
      for (int k = NST; k >= 2; k--) begin
        mValid[k] = mValid[k-1];
        mReg[k]   = mReg[k-1];
        mKind[k]  = mKind[k-1];
      end
      mValid[1] = (v && wen && wsel != 0 && !expStall) ? 1 : 0;
      mReg[1]   = wsel;
      mKind[1]  = kind;
      if (fl) begin
        mValid[1] = 0;
        mValid[2] = 0;
      end
    end else if (fl) begin
      mValid[1] = 0;
    end
    mLatched = (adv || fl) ? 1'b0 : expStall;
    #1;
  endtask

  // Look at combinational outputs for given operands without clocking.
  task automatic peek(input int rs0, input int rs1);
    bus_if.advance   = 1'b0;
    bus_if.flush     = 1'b0;
    bus_if.iss_valid = 1'b0;
    bus_if.iss_wen   = 1'b0;
    bus_if.rsel      = {REGW'(rs1), REGW'(rs0)};
    #2;
  endtask

  initial begin
    nRST = 1'b0;
    bus_if.advance   = 1'b0;
    bus_if.flush     = 1'b0;
    bus_if.iss_valid = 1'b0;
    bus_if.iss_wen   = 1'b0;
    bus_if.iss_wsel  = '0;
    bus_if.iss_kind  = '0;
    bus_if.rsel      = {REGW'(3), REGW'(5)};
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_sel0", dutSel(0), 0);
    checkOutput("rst_sel1", dutSel(1), 0);
    checkOutput("rst_kind0", dutKind(0), 0);
    checkOutput("rst_stall", int'(bus_if.stall), 0);
    @(negedge CLK);
    nRST = 1'b1;

    // ALU r3 forwards from stage 1, then stage 2.
    applyStimulus(1, 0, 1, 1, 3, 0, 0, 0);
    peek(3, 0);
    checkOutput("alu_s1_sel", dutSel(0), 1);
    checkOutput("alu_s1_kind", dutKind(0), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    peek(3, 0);
    checkOutput("alu_s2_sel", dutSel(0), 2);

    // LUI r4 on operand 1; writer of r0 never forwards.
    applyStimulus(1, 0, 1, 1, 4, 1, 0, 4);
    peek(0, 4);
    checkOutput("lui_sel1", dutSel(1), 1);
    checkOutput("lui_kind1", dutKind(1), 1);
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
    peek(0, 0);
    checkOutput("r0_sel0", dutSel(0), 0);

    // Load-use: one stalled advance, then load forwards from stage 2.
    applyStimulus(1, 0, 1, 1, 5, 2, 0, 0);
    peek(5, 0);
    checkOutput("lu_stall", int'(bus_if.stall), 1);
    applyStimulus(1, 0, 1, 1, 7, 0, 5, 0);
    peek(5, 0);
    checkOutput("lu_after_sel", dutSel(0), 2);
    checkOutput("lu_after_kind", dutKind(0), 2);
    checkOutput("lu_after_stall", int'(bus_if.stall), 0);

    // r6 in two stages: youngest wins; flush with advance drops stage 1.
    applyStimulus(1, 0, 1, 1, 6, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 6, 0, 0, 0);
    peek(6, 6);
    checkOutput("dup_sel0", dutSel(0), 1);
    checkOutput("dup_sel1", dutSel(1), 1);
    applyStimulus(1, 1, 1, 1, 9, 0, 0, 0);
    peek(6, 0);
    checkOutput("flush_adv_sel", dutSel(0), 3);

    // Stall held while the pipeline does not advance, released by advance.
    applyStimulus(1, 0, 1, 1, 8, 2, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 1, 2, 0, 8, 0);
    peek(8, 0);
    checkOutput("hold_stall", int'(bus_if.stall), 1);
    checkOutput("hold_sel", dutSel(0), 1);
    applyStimulus(1, 0, 1, 1, 2, 0, 8, 0);
    peek(8, 0);
    checkOutput("release_sel", dutSel(0), 2);
    checkOutput("release_stall", int'(bus_if.stall), 0);

    // Flush while stalled squashes the load.
    applyStimulus(1, 0, 1, 1, 9, 2, 0, 0);
    applyStimulus(0, 0, 1, 1, 2, 0, 9, 0);
    applyStimulus(0, 1, 1, 1, 2, 0, 9, 0);
    peek(9, 0);
    checkOutput("flush_stall", int'(bus_if.stall), 0);
    checkOutput("flush_sel", dutSel(0), 0);

    // Asynchronous reset in the middle of a stall.
    applyStimulus(1, 0, 1, 1, 10, 2, 0, 0);
    applyStimulus(0, 0, 1, 1, 2, 0, 10, 0);
    nRST = 1'b0;
    #1;
    checkOutput("midrst_stall", int'(bus_if.stall), 0);
    checkOutput("midrst_sel", dutSel(0), 0);
    modelReset();
    bus_if.advance = 1'b0;
    bus_if.flush   = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // Random traffic over a small register range so hits are frequent.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

`ifdef FWD_STATS_EN
    peek(0, 0);
    checkOutput("stall_cycles", int'(bus_if.stall_cycles), mStallCycles);
    checkOutput("fwd_hits", int'(bus_if.fwd_hits), mFwdHits);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
